lotr_ring_fabric: RTL and testbench

Parametrised ring interconnect, the next generation of the fixed four-tile LOTR ring. It provides NUM_STOP register-per-hop ring stops. Each stop has a local inject port (valid/ready) and a local eject port (valid/ready), so tiles no longer hard-wire the ring between them. It adds in-flight priority, eject back-pressure by recirculation, hop-age limiting with drop of undeliverable packets, and a drop counter. The LOTR top instantiates it twice, once for requests and once for responses.

---
 rtl/lotr_ring_fabric.sv | 135 +++++++++++++
 tb/tb_lotr_ring_fabric.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lotr_ring_fabric.sv
// LOTR ring fabric: NUM_STOP register-per-hop stops with local inject/eject ports,
// in-flight priority, recirculation under eject back-pressure and hop-age drop.

package lotr_pkg;
  typedef enum logic [2:0] {
    OP_READ      = 3'd0,
    OP_WRITE     = 3'd1,
    OP_READ_RESP = 3'd2,
    OP_WRITE_ACK = 3'd3,
    OP_ATOMIC    = 3'd4,
    OP_FLUSH     = 3'd5,
    OP_NOP       = 3'd6,
    OP_ERROR     = 3'd7
  } t_opcode;
endpackage

module lotr_ring_fabric
  import lotr_pkg::*;
#(
  parameter int unsigned NUM_STOP = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_LAPS = 2
) (
  input  logic                QClk,
  input  logic                RstQnnnH,
  input  logic [NUM_STOP-1:0] InjValid,
  output logic [NUM_STOP-1:0] InjReady,
  input  logic [7:0]          InjDest    [NUM_STOP],
  input  logic [7:0]          InjSrc     [NUM_STOP],
  input  t_opcode             InjOpcode  [NUM_STOP],
  input  logic [ADDR_W-1:0]   InjAddress [NUM_STOP],
  input  logic [DATA_W-1:0]   InjData    [NUM_STOP],
  output logic [NUM_STOP-1:0] EjValid,
  input  logic [NUM_STOP-1:0] EjReady,
  output logic [7:0]          EjSrc      [NUM_STOP],
  output t_opcode             EjOpcode   [NUM_STOP],
  output logic [ADDR_W-1:0]   EjAddress  [NUM_STOP],
  output logic [DATA_W-1:0]   EjData     [NUM_STOP],
  output logic [15:0]         DropCount
);

  localparam int unsigned MAX_HOPS  = NUM_STOP * MAX_LAPS;
  localparam int unsigned AGE_W     = $clog2(MAX_HOPS + 1);
  localparam int unsigned SUM_W     = $clog2(NUM_STOP + 1);
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned CNT_EXT_W = CNT_W + 1;

  typedef struct packed {
    logic              valid;
    logic [7:0]        dest;
    logic [7:0]        src;
    t_opcode           opcode;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic [AGE_W-1:0]  age;
  } t_slot;

  t_slot                slotQ [NUM_STOP];
  t_slot                slotD [NUM_STOP];
  logic [NUM_STOP-1:0]  atDest;
  logic [NUM_STOP-1:0]  eject;
  logic [NUM_STOP-1:0]  drop;
  logic [NUM_STOP-1:0]  pass;
  logic [SUM_W-1:0]     dropSum;
  logic [CNT_EXT_W-1:0] dropSumExt;
  logic [CNT_W-1:0]     dropCnt;
  logic [CNT_W-1:0]     dropCntD;

  function automatic int unsigned prevStop(input int unsigned j);
    prevStop = (j == 0) ? NUM_STOP - 1 : j - 1;
  endfunction

  // Per-stop decision: eject beats drop, anything else keeps circulating.
  always_comb begin
    atDest  = '0;
    eject   = '0;
    drop    = '0;
    pass    = '0;
    dropSum = '0;
    for (int unsigned i = 0; i < NUM_STOP; i++) begin
      atDest[i] = slotQ[i].valid && (slotQ[i].dest == 8'(i));
      eject[i]  = atDest[i] && EjReady[i];
      drop[i]   = slotQ[i].valid && !eject[i] && (slotQ[i].age == AGE_W'(MAX_HOPS));
      pass[i]   = slotQ[i].valid && !eject[i] && !drop[i];
      dropSum   = dropSum + SUM_W'(drop[i]);
    end
    dropSumExt = {1'b0, dropCnt} + CNT_EXT_W'(dropSum);
    dropCntD   = dropSumExt[CNT_W] ? {CNT_W{1'b1}} : dropSumExt[CNT_W-1:0];
  end

  assign InjReady = ~pass;
  assign EjValid  = atDest;

  // Next slot contents: passing traffic first, else the upstream stop's inject.
  always_comb begin
    for (int unsigned j = 0; j < NUM_STOP; j++) begin
      slotD[j] = '0;
      if (pass[prevStop(j)]) begin
        slotD[j]     = slotQ[prevStop(j)];
        slotD[j].age = slotQ[prevStop(j)].age + AGE_W'(1);
      end else if (InjValid[prevStop(j)]) begin
        slotD[j].valid   = 1'b1;
        slotD[j].dest    = InjDest[prevStop(j)];
        slotD[j].src     = InjSrc[prevStop(j)];
        slotD[j].opcode  = InjOpcode[prevStop(j)];
        slotD[j].address = InjAddress[prevStop(j)];
        slotD[j].data    = InjData[prevStop(j)];
        slotD[j].age     = AGE_W'(1);
      end
    end
  end

  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      for (int unsigned i = 0; i < NUM_STOP; i++) slotQ[i] <= '0;
      dropCnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_STOP; i++) slotQ[i] <= slotD[i];
      dropCnt <= dropCntD;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_STOP; i++) begin
      EjSrc[i]     = slotQ[i].src;
      EjOpcode[i]  = slotQ[i].opcode;
      EjAddress[i] = slotQ[i].address;
      EjData[i]    = slotQ[i].data;
    end
  end

  assign DropCount = dropCnt;

endmodule

// File: tb/tb_lotr_ring_fabric.sv
// Directed bench for lotr_ring_fabric (4 stops, 2 laps): delivery latency, priority,
// back-pressure recirculation, age drop, counter saturation and mid-flight reset.

module tb_lotr_ring_fabric;
  import lotr_pkg::*;

  localparam int unsigned NS = 4;

  logic          QClk;
  logic          RstQnnnH;
  logic [NS-1:0] InjValid;
  logic [NS-1:0] InjReady;
  logic [7:0]    InjDest    [NS];
  logic [7:0]    InjSrc     [NS];
  t_opcode       InjOpcode  [NS];
  logic [31:0]   InjAddress [NS];
  logic [31:0]   InjData    [NS];
  logic [NS-1:0] EjValid;
  logic [NS-1:0] EjReady;
  logic [7:0]    EjSrc      [NS];
  t_opcode       EjOpcode   [NS];
  logic [31:0]   EjAddress  [NS];
  logic [31:0]   EjData     [NS];
  logic [15:0]   DropCount;

  int nCmp = 0;
  int nErr = 0;

  lotr_ring_fabric #(
    .NUM_STOP(NS), .ADDR_W(32), .DATA_W(32), .MAX_LAPS(2)
  ) dut (
    .QClk(QClk), .RstQnnnH(RstQnnnH),
    .InjValid(InjValid), .InjReady(InjReady), .InjDest(InjDest), .InjSrc(InjSrc),
    .InjOpcode(InjOpcode), .InjAddress(InjAddress), .InjData(InjData),
    .EjValid(EjValid), .EjReady(EjReady), .EjSrc(EjSrc), .EjOpcode(EjOpcode),
    .EjAddress(EjAddress), .EjData(EjData), .DropCount(DropCount)
  );

  initial QClk = 1'b0;
  always #5 QClk = ~QClk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n active edges, then settle away from the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge QClk);
    #2;
  endtask

  task automatic clearInj();
    InjValid = '0;
    for (int s = 0; s < NS; s++) begin
      InjDest[s]    = '0;
      InjSrc[s]     = '0;
      InjOpcode[s]  = OP_READ;
      InjAddress[s] = '0;
      InjData[s]    = '0;
    end
  endtask

  task automatic inject(input int s, input logic [7:0] dst, input logic [7:0] src,
                        input logic [31:0] addr, input logic [31:0] dat);
    InjValid[s]   = 1'b1;
    InjDest[s]    = dst;
    InjSrc[s]     = src;
    InjOpcode[s]  = OP_WRITE;
    InjAddress[s] = addr;
    InjData[s]    = dat;
  endtask

  logic [NS-1:0] seen;

  initial begin
    RstQnnnH = 1'b1;
    EjReady  = '1;
    clearInj();
    tick(2);
    chk("rst_ejvalid", 32'(EjValid), 32'h0);
    chk("rst_injready", 32'(InjReady), 32'hF);
    chk("rst_dropcount", 32'(DropCount), 32'h0);
    RstQnnnH = 1'b0;
    tick(1);

    // Basic delivery 0 -> 2
    inject(0, 8'd2, 8'h05, 32'h1000, 32'hDEADBEEF);
    #1;
    chk("basic_injready0", 32'(InjReady[0]), 32'h1);
    tick(1); clearInj();
    chk("basic_t1_idle", 32'(EjValid), 32'h0);
    tick(1);
    chk("basic_ejvalid", 32'(EjValid), 32'h4);
    chk("basic_src", 32'(EjSrc[2]), 32'h05);
    chk("basic_addr", EjAddress[2], 32'h1000);
    chk("basic_data", EjData[2], 32'hDEADBEEF);
    chk("basic_opcode", 32'(EjOpcode[2]), 32'(OP_WRITE));
    tick(1);
    chk("basic_gone", 32'(EjValid), 32'h0);
    chk("basic_dropcount", 32'(DropCount), 32'h0);

    // Self-destined: full lap
    inject(1, 8'd1, 8'h11, 32'h2000, 32'h11111111);
    tick(1); clearInj();
    tick(2);
    chk("self_t3", 32'(EjValid), 32'h0);
    tick(1);
    chk("self_t4", 32'(EjValid), 32'h2);
    chk("self_data", EjData[1], 32'h11111111);
    tick(1);
    chk("self_gone", 32'(EjValid), 32'h0);

    // Contention: in-flight packet blocks inject at stop 1
    inject(0, 8'd3, 8'h20, 32'h3000, 32'hAAAA0003);
    tick(1); clearInj();
    inject(1, 8'd2, 8'h21, 32'h3100, 32'hAAAA0102);
    #1;
    chk("cont_stall", 32'(InjReady), 32'hD);
    tick(1); #1;
    chk("cont_accept", 32'(InjReady), 32'hB);
    tick(1); clearInj();
    chk("cont_arrive", 32'(EjValid), 32'hC);
    chk("cont_data3", EjData[3], 32'hAAAA0003);
    chk("cont_data2", EjData[2], 32'hAAAA0102);
    tick(1);
    chk("cont_no_dup", 32'(EjValid), 32'h0);

    // Same-cycle eject and inject at stop 2
    inject(0, 8'd2, 8'h30, 32'h4000, 32'hBBBB0002);
    tick(1); clearInj();
    tick(1);
    EjReady[2] = 1'b0;
    #1;
    chk("same_bp_injready", 32'(InjReady[2]), 32'h0);
    EjReady[2] = 1'b1;
    inject(2, 8'd3, 8'h32, 32'h4200, 32'hBBBB0203);
    #1;
    chk("same_injready", 32'(InjReady[2]), 32'h1);
    chk("same_ejvalid", 32'(EjValid), 32'h4);
    chk("same_ejdata", EjData[2], 32'hBBBB0002);
    tick(1); clearInj();
    chk("same_arrive", 32'(EjValid), 32'h8);
    chk("same_data", EjData[3], 32'hBBBB0203);
    tick(1);
    chk("same_gone", 32'(EjValid), 32'h0);

    // Back-pressure until aged out
    EjReady[2] = 1'b0;
    inject(0, 8'd2, 8'h40, 32'h5000, 32'hCCCC0002);
    tick(1); clearInj();
    tick(1);
    chk("bp_t2", 32'(EjValid), 32'h4);
    tick(1);
    chk("bp_t3", 32'(EjValid), 32'h0);
    tick(3);
    chk("bp_t6", 32'(EjValid), 32'h4);
    tick(1);
    chk("bp_t7_count", 32'(DropCount), 32'h0);
    tick(1);
    chk("bp_t8_injready", 32'(InjReady), 32'hF);
    tick(1);
    chk("bp_t9_count", 32'(DropCount), 32'h1);
    tick(1);
    chk("bp_t10_gone", 32'(EjValid), 32'h0);

    // Same, but consumed on the second lap
    inject(0, 8'd2, 8'h41, 32'h5100, 32'hCCCC0102);
    tick(1); clearInj();
    tick(1);
    chk("bp2_t2", 32'(EjValid), 32'h4);
    tick(4);
    EjReady[2] = 1'b1;
    chk("bp2_t6", 32'(EjValid), 32'h4);
    chk("bp2_t6_data", EjData[2], 32'hCCCC0102);
    tick(1);
    chk("bp2_t7", 32'(EjValid), 32'h0);
    tick(2);
    chk("bp2_count", 32'(DropCount), 32'h1);

    // Unroutable destination
    inject(1, 8'd7, 8'h50, 32'h6000, 32'h77777777);
    tick(1); clearInj();
    tick(3);
    chk("unr_t4", 32'(EjValid), 32'h0);
    tick(3);
    chk("unr_t7_count", 32'(DropCount), 32'h1);
    tick(2);
    chk("unr_t9_count", 32'(DropCount), 32'h2);

    // Saturation: three simultaneous drops from 16'hFFFE
    inject(0, 8'd7, 8'h60, 32'h7000, 32'h60);
    inject(1, 8'd7, 8'h61, 32'h7100, 32'h61);
    inject(2, 8'd7, 8'h62, 32'h7200, 32'h62);
    tick(1); clearInj();
    force dut.dropCnt = 16'hFFFE;
    tick(1);
    release dut.dropCnt;
    chk("sat_preload", 32'(DropCount), 32'hFFFE);
    tick(7);
    chk("sat_count", 32'(DropCount), 32'hFFFF);

    // Reset mid-flight with every slot occupied
    EjReady = '0;
    for (int s = 0; s < NS; s++)
      inject(s, 8'((s + 2) % NS), 8'(8'h70 + s), 32'h8000, 32'(32'h80 + s));
    tick(1); clearInj();
    chk("rstmf_full", 32'(InjReady), 32'h0);
    RstQnnnH = 1'b1;
    inject(0, 8'd1, 8'h7F, 32'h8F00, 32'hFFFF0001);
    tick(1);
    RstQnnnH = 1'b0;
    clearInj();
    EjReady = '1;
    #1;
    chk("rstmf_ejvalid", 32'(EjValid), 32'h0);
    chk("rstmf_injready", 32'(InjReady), 32'hF);
    chk("rstmf_count", 32'(DropCount), 32'h0);
    seen = '0;
    repeat (12) begin
      tick(1);
      seen = seen | EjValid;
    end
    chk("rstmf_no_stale", 32'(seen), 32'h0);
    chk("rstmf_count_end", 32'(DropCount), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
